// File: rtl/lsu_v2_if.sv
// Execute-stage <-> LSU request/response bundle: one-cycle request in,
// registered load data, valid and misalign pulses out.
interface lsu_v2_if;
    logic        i_req;
    logic        i_lsu_wren;
    logic [31:0] i_lsu_addr;
    logic [2:0]  i_funct3;
    logic [31:0] i_st_data;
    logic [31:0] o_ld_data;
    logic        o_data_vld;
    logic        o_misalign;

    modport master (
        output i_req, i_lsu_wren, i_lsu_addr, i_funct3, i_st_data,
        input  o_ld_data, o_data_vld, o_misalign
    );

    modport slave (
        input  i_req, i_lsu_wren, i_lsu_addr, i_funct3, i_st_data,
        output o_ld_data, o_data_vld, o_misalign
    );
endinterface

// File: rtl/lsu_v2.sv
// RV32I load/store unit with data memory and board MMIO, 1-cycle load latency.
// Optional macro LSU_HEX_DECODE_EN: drive HEX digits through a 7-segment decoder.
module lsu_v2 #(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_2000,
    parameter int          DMEM_WORDS = 2048,
    parameter int          NUM_HEX    = 8,
    parameter int          BTN_WIDTH  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    lsu_v2_if.slave              bus,
    input  logic [31:0]          i_io_sw,
    input  logic [BTN_WIDTH-1:0] i_io_btn,
    output logic [31:0]          o_io_ledr,
    output logic [31:0]          o_io_ledg,
    output logic [31:0]          o_io_lcd,
    output logic [7*NUM_HEX-1:0] o_io_hex
);

    localparam int          AW        = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_SPAN = 32'(4 * DMEM_WORDS);
    localparam logic [29:0] LEDR_W    = 30'h1C00;
    localparam logic [29:0] LEDG_W    = 30'h1C04;
    localparam logic [29:0] HEX_W     = 30'h1C08;
    localparam logic [29:0] LCD_W     = 30'h1C0C;
    localparam logic [29:0] SW_W      = 30'h1E00;
    localparam logic [29:0] BTN_W     = 30'h1E04;

    function automatic logic [3:0] strb_gen(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            3'b010:  return sh;
            default: return 32'd0;
        endcase
    endfunction

`ifdef LSU_HEX_DECODE_EN
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction
`endif

    logic [31:0] ledr_q, ledg_q, lcd_q;
    logic [7:0]  hex_q [NUM_HEX];
    logic [31:0] dmem [DMEM_WORDS];

    logic [31:0] addr_p0, wdat_p0, mmio_word_p0;
    logic [29:0] word_p0;
    logic [2:0]  f3_p0;
    logic [1:0]  lane_p0;
    logic [3:0]  strb_p0;
    logic [AW-1:0] idx_p0;
    logic        supp_p0, mis_p0, acc_p0, wr_p0, rd_p0;
    logic        hit_dmem_p0, hit_hex_p0, hex_sel_p0, mmio_hit_p0;

    logic [31:0] dmem_rd_p1, mmio_rd_p1;
    logic [2:0]  f3_p1;
    logic [1:0]  lane_p1;
    logic        vld_p1, mis_p1, zero_p1, dsel_p1;

    // ---- stage p0: request decode, strobes, MMIO read mux ----
    assign addr_p0     = bus.i_lsu_addr;
    assign word_p0     = addr_p0[31:2];
    assign lane_p0     = addr_p0[1:0];
    assign f3_p0       = bus.i_funct3;
    assign idx_p0      = addr_p0[AW+1:2];
    assign supp_p0     = (f3_p0 != 3'b011) && (f3_p0[2:1] != 2'b11);
    assign mis_p0      = supp_p0 && ((f3_p0[1:0] == 2'b01 && addr_p0[0]) ||
                                     (f3_p0[1:0] == 2'b10 && addr_p0[1:0] != 2'b00));
    assign acc_p0      = bus.i_req && supp_p0 && !mis_p0;
    assign wr_p0       = acc_p0 && bus.i_lsu_wren;
    assign rd_p0       = acc_p0 && !bus.i_lsu_wren;
    assign strb_p0     = strb_gen(f3_p0, lane_p0);
    assign wdat_p0     = lane_rep(f3_p0, bus.i_st_data);
    assign hit_dmem_p0 = (addr_p0 & ~(DMEM_SPAN - 32'd1)) == DMEM_BASE;
    // The second HEX word only exists when there are more than four digits.
    assign hit_hex_p0  = (word_p0 == HEX_W) || (NUM_HEX > 4 && word_p0 == HEX_W + 30'd1);
    assign hex_sel_p0  = addr_p0[2];

    always_comb begin
        mmio_hit_p0  = 1'b1;
        mmio_word_p0 = '0;
        if (word_p0 == LEDR_W)      mmio_word_p0 = ledr_q;
        else if (word_p0 == LEDG_W) mmio_word_p0 = ledg_q;
        else if (word_p0 == LCD_W)  mmio_word_p0 = lcd_q;
        else if (word_p0 == SW_W)   mmio_word_p0 = i_io_sw;
        else if (word_p0 == BTN_W)  mmio_word_p0 = 32'(i_io_btn);
        else if (hit_hex_p0) begin
            for (int d = 0; d < NUM_HEX; d++)
                if ((d / 4) == int'(hex_sel_p0)) mmio_word_p0[8*(d%4) +: 8] = hex_q[d];
        end else
            mmio_hit_p0 = 1'b0;
    end

    // ---- stage p0 -> p1: control and MMIO registers ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ledr_q  <= '0;
            ledg_q  <= '0;
            lcd_q   <= '0;
            for (int d = 0; d < NUM_HEX; d++) hex_q[d] <= '0;
            vld_p1  <= 1'b0;
            mis_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            dsel_p1 <= 1'b0;
            f3_p1   <= '0;
            lane_p1 <= '0;
        end else begin
            vld_p1  <= bus.i_req && (!supp_p0 || (!mis_p0 && !bus.i_lsu_wren));
            mis_p1  <= bus.i_req && mis_p0;
            zero_p1 <= !supp_p0 || !(hit_dmem_p0 || mmio_hit_p0);
            dsel_p1 <= hit_dmem_p0;
            f3_p1   <= f3_p0;
            lane_p1 <= lane_p0;
            if (wr_p0 && word_p0 == LEDR_W) ledr_q <= merge(ledr_q, wdat_p0, strb_p0);
            if (wr_p0 && word_p0 == LEDG_W) ledg_q <= merge(ledg_q, wdat_p0, strb_p0);
            if (wr_p0 && word_p0 == LCD_W)  lcd_q  <= merge(lcd_q, wdat_p0, strb_p0);
            for (int d = 0; d < NUM_HEX; d++)
                if (wr_p0 && hit_hex_p0 && (d / 4) == int'(hex_sel_p0) && strb_p0[2'(d % 4)])
                    hex_q[d] <= wdat_p0[8*(d%4) +: 8];
        end
    end

    // ---- stage p0 -> p1: data memory and read-data capture ----
    always_ff @(posedge i_clk) begin
        if (wr_p0 && hit_dmem_p0)
            for (int b = 0; b < 4; b++)
                if (strb_p0[b]) dmem[idx_p0][8*b +: 8] <= wdat_p0[8*b +: 8];
        if (rd_p0) begin
            dmem_rd_p1 <= dmem[idx_p0];
            mmio_rd_p1 <= mmio_word_p0;
        end
    end

    // ---- stage p1: lane select, extension, outputs ----
    assign bus.o_ld_data  = (vld_p1 && !zero_p1) ?
                            load_ext(dsel_p1 ? dmem_rd_p1 : mmio_rd_p1, lane_p1, f3_p1) : 32'd0;
    assign bus.o_data_vld = vld_p1;
    assign bus.o_misalign = mis_p1;

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;

    for (genvar d = 0; d < NUM_HEX; d++) begin : g_hex
`ifdef LSU_HEX_DECODE_EN
        assign o_io_hex[7*d +: 7] = hex_q[d][7] ? 7'h7F : seg7(hex_q[d][3:0]);
`else
        assign o_io_hex[7*d +: 7] = hex_q[d][6:0];
`endif
    end

endmodule

// File: tb/tb_lsu_v2.sv
// Scoreboard bench for lsu_v2: directed loads/stores, MMIO, misalign and reset cases.
module tb_lsu_v2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] sw;
    logic [3:0]  btn;
    logic [31:0] ledr, ledg, lcd;
    logic [55:0] hex;

    lsu_v2_if bus();

    lsu_v2 dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .bus       (bus),
        .i_io_sw   (sw),
        .i_io_btn  (btn),
        .o_io_ledr (ledr),
        .o_io_ledg (ledg),
        .o_io_lcd  (lcd),
        .o_io_hex  (hex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

`ifdef LSU_HEX_DECODE_EN
    localparam logic [6:0] HEX0_RST = 7'b1000000;
    localparam logic [6:0] HEX2_EXP = 7'b0010010;
    localparam logic [6:0] HEX3_EXP = 7'h7F;
`else
    localparam logic [6:0] HEX0_RST = 7'h00;
    localparam logic [6:0] HEX2_EXP = 7'h05;
    localparam logic [6:0] HEX3_EXP = 7'h05;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: every vld/misalign pulse must match the oldest expectation, one cycle after issue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (bus.o_data_vld || bus.o_misalign)) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: vld=%b mis=%b data=%h, expected no pulse",
                         bus.o_data_vld, bus.o_misalign, bus.o_ld_data);
            end else begin
                e = sb.pop_front();
                chk({e.name, " vld"}, 32'(bus.o_data_vld), 32'(!e.mis));
                chk({e.name, " mis"}, 32'(bus.o_misalign), 32'(e.mis));
                chk({e.name, " latency"}, 32'(cyc - e.cyc), 32'd1);
                if (!e.mis) chk({e.name, " data"}, bus.o_ld_data, e.data);
            end
        end
    end

    task automatic drive(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] d);
        @(negedge clk);
        bus.i_req      = 1'b1;
        bus.i_lsu_wren = wr;
        bus.i_lsu_addr = a;
        bus.i_funct3   = f3;
        bus.i_st_data  = d;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_req = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
        drive(1'b1, a, f3, d);
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] exp,
                      input string nm);
        drive(1'b0, a, f3, 32'd0);
        sb.push_back('{1'b0, exp, cyc, nm});
    endtask

    task automatic misreq(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] d, input string nm);
        drive(wr, a, f3, d);
        sb.push_back('{1'b1, 32'd0, cyc, nm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.i_req      = 1'b0;
        bus.i_lsu_wren = 1'b0;
        bus.i_lsu_addr = '0;
        bus.i_funct3   = '0;
        bus.i_st_data  = '0;
        sw             = '0;
        btn            = '0;
        repeat (2) @(negedge clk);
        chk("rst vld", 32'(bus.o_data_vld), 32'd0);
        chk("rst mis", 32'(bus.o_misalign), 32'd0);
        chk("rst ld_data", bus.o_ld_data, 32'd0);
        chk("rst ledr", ledr, 32'd0);
        chk("rst ledg", ledg, 32'd0);
        chk("rst lcd", lcd, 32'd0);
        chk("rst hex0", 32'(hex[6:0]), 32'(HEX0_RST));
        rst_n = 1'b1;

        // Sub-word loads with sign/zero extension
        st(32'h2004, 3'b010, 32'hDEADBEEF);
        ld(32'h2005, 3'b000, 32'hFFFFFFBE, "lb");
        ld(32'h2005, 3'b100, 32'h000000BE, "lbu");
        ld(32'h2006, 3'b001, 32'hFFFFDEAD, "lh");
        ld(32'h2006, 3'b101, 32'h0000DEAD, "lhu");
        ld(32'h2004, 3'b010, 32'hDEADBEEF, "lw");

        // HEX byte registers
        st(32'h7020, 3'b010, 32'h03020100);
        st(32'h7022, 3'b000, 32'h00000005);
        ld(32'h7020, 3'b010, 32'h03050100, "hex_word");
        st(32'h7023, 3'b000, 32'h00000085);
        ld(32'h7023, 3'b100, 32'h00000085, "hex_bit7");
        idle();
        chk("hex digit2", 32'(hex[20:14]), 32'(HEX2_EXP));
        chk("hex digit3", 32'(hex[27:21]), 32'(HEX3_EXP));

        // Misaligned accesses leave memory untouched
        st(32'h2000, 3'b010, 32'h11223344);
        misreq(1'b0, 32'h2002, 3'b010, 32'd0, "lw_mis");
        misreq(1'b1, 32'h2003, 3'b001, 32'h0000AAAA, "sh_mis");
        misreq(1'b0, 32'h2001, 3'b101, 32'd0, "lhu_mis");
        ld(32'h2000, 3'b010, 32'h11223344, "after_mis");

        // Read-after-write and DMEM edges
        st(32'h2FFC, 3'b010, 32'h12345678);
        ld(32'h2FFC, 3'b010, 32'h12345678, "raw");
        ld(32'h4000, 3'b010, 32'h00000000, "above_dmem");
        ld(32'h1FFC, 3'b010, 32'h00000000, "below_dmem");
        idle();

        // Switches, buttons, unmapped and unsupported funct3
        btn = 4'b1010;
        sw  = 32'h0000BEEF;
        ld(32'h7810, 3'b010, 32'h0000000A, "btn");
        ld(32'h7800, 3'b010, 32'h0000BEEF, "sw");
        ld(32'h9000, 3'b010, 32'h00000000, "unmapped");
        st(32'h7800, 3'b010, 32'h00001234);
        ld(32'h7800, 3'b010, 32'h0000BEEF, "sw_readonly");
        ld(32'h2004, 3'b011, 32'h00000000, "bad_f3");

        // LED/LCD partial writes
        st(32'h7010, 3'b010, 32'hA5A5A5A5);
        st(32'h7012, 3'b001, 32'h00001234);
        st(32'h7031, 3'b000, 32'h0000007F);
        st(32'h7000, 3'b010, 32'h0000FFFF);
        ld(32'h7010, 3'b010, 32'h1234A5A5, "ledg_rd");
        idle();
        chk("ledg", ledg, 32'h1234A5A5);
        chk("lcd", lcd, 32'h00007F00);
        chk("ledr", ledr, 32'h0000FFFF);
        idle();
        chk("sb drained", 32'(sb.size()), 32'd0);

        // Reset during an in-flight load
        drive(1'b0, 32'h2004, 3'b010, 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.i_req = 1'b0;
        #1;
        chk("midrst vld", 32'(bus.o_data_vld), 32'd0);
        chk("midrst ld_data", bus.o_ld_data, 32'd0);
        chk("midrst ledr", ledr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst vld", 32'(bus.o_data_vld), 32'd0);
        end
        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
